mcs_wait_bridge: RTL and testbench
==================================

MCS_WAIT_BRIDGE -- requirements
Module: mcs_wait_bridge

Interface
REQ-001 SHALL have parameter BRG_BASE, default 32'hc000_0000; bridge base address, only bits [31:24] compared.
REQ-002 SHALL have parameter TIMEOUT, default 16; max FPro wait cycles, range 2..255.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- io_addr_strobe  in  1  MCS access strobe; unused.
- io_read_strobe  in  1  MCS read request.
- io_write_strobe  in  1  MCS write request.
- io_byte_enable  in  4  MCS byte lanes.
- io_address  in  32  MCS byte address.
- io_write_data  in  32  MCS write data.
- io_read_data  out  32  read response.
- io_ready  out  1  one-cycle completion pulse.
- fp_video_cs  out  1  video slot select.
- fp_mmio_cs  out  1  mmio slot select.
- fp_wr  out  1  FPro write pulse.
- fp_rd  out  1  FPro read pulse.
- fp_addr  out  21  word address.
- fp_wr_data  out  32  write data.
- fp_rd_data  in  32  slave read data.
- fp_ready  in  1  slave acknowledge.
- err_sticky  out  1  timeout or partial-write flag.
- timeout_cnt  out  8  saturating timeout count.

Function
REQ-004 SHALL use FSM states IDLE, ACCESS, WAIT, RESP.
REQ-005 IDLE: on io_read_strobe or io_write_strobe, SHALL register address, write data and byte enables, then go to ACCESS. If both strobes are high, the request SHALL be a write.
REQ-006 In-range when io_address[31:24]==BRG_BASE[31:24]; io_address[23]=1 selects video, 0 selects mmio.
REQ-007 fp_addr SHALL be the registered io_address[22:2].
REQ-008 ACCESS (one cycle):
- SHALL assert the selected cs plus fp_rd or fp_wr for exactly that cycle.
- fp_rd, fp_wr and cs SHALL be 0 in all other states.
- If fp_ready=1 in ACCESS, go to RESP; else go to WAIT.
REQ-009 WAIT: cs held asserted, fp_rd/fp_wr deasserted.
- Wait counter SHALL increment each WAIT cycle.
- fp_ready=1 SHALL go to RESP.
- Counter reaching TIMEOUT-1 without fp_ready SHALL go to RESP as a timeout.
REQ-010 fp_rd_data SHALL be captured on the cycle fp_ready=1 (ACCESS or WAIT) when the request is a read.
REQ-011 RESP: io_ready=1 for exactly one cycle, io_read_data valid that cycle, then return to IDLE.
REQ-012 Read data in RESP:
- captured data on a normal read;
- 32'hdead_beef on a timeout;
- 0 on an out-of-range read;
- don't-care for writes.
REQ-013 Out-of-range access: no cs/fp_rd/fp_wr; SHALL go directly IDLE->RESP, so io_ready arrives 2 cycles after the strobe.
REQ-014 Write with io_byte_enable != 4'b1111: fp_wr SHALL NOT assert; SHALL go IDLE->RESP and set err_sticky.
REQ-015 Timeout SHALL set err_sticky and increment timeout_cnt, saturating at 255.
REQ-016 Strobes arriving outside IDLE SHALL be ignored.
REQ-017 Best-case latency: strobe at cycle 0, fp_rd/fp_wr at cycle 1, fp_ready at cycle 1, io_ready at cycle 2.
REQ-018 Outputs SHALL be registered; fp_rd_data and fp_ready SHALL have no combinational path to io_*.

Reset
REQ-019 Reset SHALL set:
- FSM to IDLE;
- io_ready, fp_rd, fp_wr, both cs to 0;
- io_read_data, fp_addr, fp_wr_data to 0;
- err_sticky, timeout_cnt and the wait counter to 0.
REQ-020 Reset mid-transaction SHALL abort it: no io_ready is issued, and outputs are deasserted on the next edge.

Structure
REQ-021 State enum and DEAD_BEEF constant SHALL live in shared package mcs_brg_pkg.
REQ-022 Sub-module wait_timer SHALL hold the wait counter, with clear/enable inputs and an expire output.

Verification
REQ-023 Read 0xc000_0010, fp_ready at cycle 1 with fp_rd_data=0x1234_5678 -> fp_mmio_cs and fp_rd at cycle 1, fp_addr=0x4, io_ready at cycle 2 with io_read_data=0x1234_5678.
REQ-024 Write 0xc080_0008, data 0xa5a5_a5a5, fp_ready after 3 wait cycles -> fp_video_cs, single fp_wr pulse, fp_addr=0x2, exactly one io_ready pulse.
REQ-025 Read 0xc000_0000 with fp_ready never asserted and TIMEOUT=16 -> io_ready 16 cycles after ACCESS, io_read_data=0xdead_beef, err_sticky=1, timeout_cnt=1.
REQ-026 Read 0x8000_0000 -> no cs, io_ready at cycle 2, io_read_data=0; byte_enable=4'b0011 write -> no fp_wr, err_sticky=1.
REQ-027 Reset asserted during WAIT -> no io_ready, all outputs 0 next cycle; a subsequent read completes normally.
REQ-028 Both strobes high simultaneously -> write performed; 300 forced timeouts -> timeout_cnt=255.

Source files
------------

// File: rtl/mcs_brg_pkg.sv
// mcs_brg_pkg: shared FSM states and constants for the MCS-to-FPro wait bridge
package mcs_brg_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic [31:0] DEAD_BEEF = 32'hdead_beef;
  localparam logic [7:0] TCNT_MAX = 8'hff;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts WAIT cycles and flags the cycle on which the count reaches TIMEOUT-1
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt;
  // Count restarts from zero whenever the bridge is not waiting
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expire = en && cnt == 8'(TIMEOUT - 2);
endmodule

// File: rtl/mcs_wait_bridge.sv
// mcs_wait_bridge: MCS IO bus to FPro bus bridge with wait states, timeout and error reporting
module mcs_wait_bridge
  import mcs_brg_pkg::*;
#(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        fp_video_cs,
  output logic        fp_mmio_cs,
  output logic        fp_wr,
  output logic        fp_rd,
  output logic [20:0] fp_addr,
  output logic [31:0] fp_wr_data,
  input  logic [31:0] fp_rd_data,
  input  logic        fp_ready,
  output logic        err_sticky,
  output logic [7:0]  timeout_cnt
);
  state_t state, nxt;
  logic wr_q, vid_q;
  logic req, hit, part, expire, timed_out, cap;
  logic ready_d, rd_d, wr_d, vcs_d, mcs_d;
  logic [31:0] rdata_d;
  logic unused;
  assign unused = ^{io_addr_strobe, io_address[1:0]};
  assign req = state == IDLE && (io_read_strobe || io_write_strobe);
  assign hit = io_address[31:24] == BRG_BASE[31:24];
  assign part = io_write_strobe && io_byte_enable != 4'hf;
  assign timed_out = state == WAIT && expire && !fp_ready;
  assign cap = (state == ACCESS || state == WAIT) && fp_ready && !wr_q;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(reset),
    .clr(state != WAIT),
    .en(state == WAIT),
    .expire(expire)
  );

  // Next state plus the next values of every registered output
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !req ? IDLE : (hit && !part) ? ACCESS : RESP;
      ACCESS:  nxt = fp_ready ? RESP : WAIT;
      WAIT:    nxt = (fp_ready || expire) ? RESP : WAIT;
      default: nxt = io_ready ? IDLE : RESP;
    endcase
    rd_d = nxt == ACCESS && !io_write_strobe;
    wr_d = nxt == ACCESS && io_write_strobe;
    vcs_d = (nxt == ACCESS && io_address[23]) || (nxt == WAIT && vid_q);
    mcs_d = (nxt == ACCESS && !io_address[23]) || (nxt == WAIT && !vid_q);
    ready_d = (nxt == RESP && (state == ACCESS || state == WAIT)) || (state == RESP && !io_ready);
    rdata_d = (state == IDLE && nxt == RESP) ? '0 : cap ? fp_rd_data : timed_out ? DEAD_BEEF : io_read_data;
  end

  // State and output registers; a request is latched only when accepted in IDLE
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      io_ready <= 1'b0;
      fp_rd <= 1'b0;
      fp_wr <= 1'b0;
      fp_video_cs <= 1'b0;
      fp_mmio_cs <= 1'b0;
      io_read_data <= '0;
      fp_addr <= '0;
      fp_wr_data <= '0;
      err_sticky <= 1'b0;
      timeout_cnt <= '0;
      wr_q <= 1'b0;
      vid_q <= 1'b0;
    end else begin
      state <= nxt;
      io_ready <= ready_d;
      fp_rd <= rd_d;
      fp_wr <= wr_d;
      fp_video_cs <= vcs_d;
      fp_mmio_cs <= mcs_d;
      io_read_data <= rdata_d;
      if (req) begin
        wr_q <= io_write_strobe;
        vid_q <= io_address[23];
        fp_addr <= io_address[22:2];
        fp_wr_data <= io_write_data;
      end
      if (timed_out || (req && part)) err_sticky <= 1'b1;
      if (timed_out && timeout_cnt != TCNT_MAX) timeout_cnt <= timeout_cnt + 8'd1;
    end
endmodule

// File: tb/tb_mcs_wait_bridge.sv
// tb_mcs_wait_bridge: scoreboard bench with a latency-programmable FPro slave and a transaction-level model
module tb_mcs_wait_bridge;
  localparam int TO = 16;
  localparam int NEVER = 1000;
  logic clk = 0, reset = 1;
  logic io_addr_strobe = 0, io_read_strobe = 0, io_write_strobe = 0;
  logic [3:0] io_byte_enable = 0;
  logic [31:0] io_address = 0, io_write_data = 0, io_read_data;
  logic io_ready, fp_video_cs, fp_mmio_cs, fp_wr, fp_rd, err_sticky;
  logic [20:0] fp_addr;
  logic [31:0] fp_wr_data, fp_rd_data;
  logic fp_ready;
  logic [7:0] timeout_cnt;
  int cyc = 0, errs = 0, checks = 0;
  int slave_lat = NEVER;
  logic [31:0] slave_data = 0;
  int m_err = 0, m_tcnt = 0;
  typedef struct {
    int s; int l; bit rd; bit acc; bit vid;
    logic [20:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    int err; int tcnt;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [1:0] cs_e;
  logic rd_e, wr_e;

  mcs_wait_bridge #(.BRG_BASE(32'hc000_0000), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .io_addr_strobe(io_addr_strobe),
    .io_read_strobe(io_read_strobe), .io_write_strobe(io_write_strobe),
    .io_byte_enable(io_byte_enable), .io_address(io_address),
    .io_write_data(io_write_data), .io_read_data(io_read_data), .io_ready(io_ready),
    .fp_video_cs(fp_video_cs), .fp_mmio_cs(fp_mmio_cs), .fp_wr(fp_wr), .fp_rd(fp_rd),
    .fp_addr(fp_addr), .fp_wr_data(fp_wr_data), .fp_rd_data(fp_rd_data),
    .fp_ready(fp_ready), .err_sticky(err_sticky), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // FPro slave: acknowledges lat cycles after the access pulse; data is garbage except on the ack cycle
  initial begin
    fp_ready = 0;
    fp_rd_data = 0;
    forever begin
      @(negedge clk);
      fp_rd_data = $urandom;
      if ((fp_rd || fp_wr) && !reset && slave_lat < NEVER) begin
        repeat (slave_lat) begin
          @(negedge clk);
          fp_rd_data = $urandom;
        end
        fp_ready = 1;
        fp_rd_data = slave_data;
        @(negedge clk);
        fp_ready = 0;
        fp_rd_data = $urandom;
      end
    end
  end

  // Monitor: bus-side pulses every cycle, response checked against the scoreboard head
  always @(negedge clk) if (!reset) begin
    cs_e = 0; rd_e = 0; wr_e = 0;
    if (q.size() > 0) begin
      me = q[0];
      if (me.acc && cyc >= me.s + 1 && cyc <= me.s + me.l - 1) cs_e = me.vid ? 2'b10 : 2'b01;
      rd_e = me.acc && cyc == me.s + 1 && me.rd;
      wr_e = me.acc && cyc == me.s + 1 && !me.rd;
    end
    chk("cs", 32'({fp_video_cs, fp_mmio_cs}), 32'(cs_e));
    chk("rd_wr_pulse", 32'({fp_rd, fp_wr}), 32'({rd_e, wr_e}));
    if (rd_e || wr_e) chk("fp_addr", 32'(fp_addr), 32'(me.addr));
    if (wr_e) chk("fp_wr_data", fp_wr_data, me.wdata);
    if (io_ready) begin
      if (q.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_io_ready at cycle %0d", cyc);
      end else begin
        me = q.pop_front();
        chk("latency", cyc - me.s, me.l);
        if (me.rd) chk("io_read_data", io_read_data, me.rdata);
        chk("err_sticky", 32'(err_sticky), me.err);
        chk("timeout_cnt", 32'(timeout_cnt), me.tcnt);
      end
    end else if (q.size() > 0 && cyc > q[0].s + q[0].l) begin
      checks++; errs++;
      $display("FAIL missing_io_ready: none by cycle %0d expected at %0d", cyc, q[0].s + q[0].l);
      void'(q.pop_front());
    end
  end

  // One transaction: model the outcome, issue the strobe, optionally spray ignored strobes while busy
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input int lat, input logic [31:0] sd, input bit noise);
    exp_t e;
    bit part;
    part = wr && be != 4'hf;
    e.rd = !wr; e.acc = a[31:24] == 8'hc0 && !part; e.vid = a[23];
    e.addr = a[22:2]; e.wdata = wd; e.rdata = 0;
    if (!e.acc) begin
      e.l = 2;
      if (part) m_err = 1;
    end else if (lat <= TO - 1) begin
      e.l = 2 + lat;
      e.rdata = sd;
    end else begin
      e.l = TO + 1;
      e.rdata = 32'hdead_beef;
      m_err = 1;
      m_tcnt = m_tcnt == 255 ? 255 : m_tcnt + 1;
    end
    e.err = m_err; e.tcnt = m_tcnt;
    @(posedge clk); #1;
    slave_lat = lat; slave_data = sd;
    io_read_strobe = rd; io_write_strobe = wr; io_address = a;
    io_byte_enable = be; io_write_data = wd; io_addr_strobe = 1;
    e.s = cyc;
    q.push_back(e);
    for (int c = 0; c < e.l; c++) begin
      @(posedge clk); #1;
      io_read_strobe = noise && $urandom_range(3) == 0;
      io_write_strobe = noise && $urandom_range(3) == 0;
      io_address = {8'hc0, 24'($urandom)};
      io_byte_enable = 4'hf; io_write_data = $urandom; io_addr_strobe = 0;
    end
    @(posedge clk); #1;
    io_read_strobe = 0; io_write_strobe = 0;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'({io_ready, fp_rd, fp_wr, fp_video_cs, fp_mmio_cs, err_sticky}), 0);
    chk("rst_rdata", io_read_data, 0);
    chk("rst_addr", 32'(fp_addr), 0);
    chk("rst_wdata", fp_wr_data, 0);
    chk("rst_tcnt", 32'(timeout_cnt), 0);
    @(posedge clk); #1 reset = 0;
    issue(1, 0, 32'hc000_0010, 4'hf, 0, 0, 32'h1234_5678, 0);
    issue(0, 1, 32'hc080_0008, 4'hf, 32'ha5a5_a5a5, 3, $urandom, 0);
    issue(1, 0, 32'hc000_0000, 4'hf, 0, NEVER, $urandom, 0);
    issue(1, 0, 32'h8000_0000, 4'hf, 0, 0, $urandom, 0);
    issue(0, 1, 32'hc000_0020, 4'b0011, 32'h5555_0000, 0, $urandom, 0);
    // Reset while the bridge is in WAIT: the transaction must vanish
    @(posedge clk); #1;
    slave_lat = NEVER;
    io_read_strobe = 1; io_address = 32'hc000_0040; io_byte_enable = 4'hf;
    e.s = cyc; e.l = NEVER; e.rd = 1; e.acc = 1; e.vid = 0; e.addr = 21'h10;
    e.wdata = 0; e.rdata = 0; e.err = m_err; e.tcnt = m_tcnt;
    q.push_back(e);
    @(posedge clk); #1 io_read_strobe = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    q.delete();
    @(posedge clk); #1 reset = 0;
    m_err = 0; m_tcnt = 0;
    @(negedge clk);
    chk("abort_outs", 32'({io_ready, fp_rd, fp_wr, fp_video_cs, fp_mmio_cs, err_sticky}), 0);
    chk("abort_rdata", io_read_data, 0);
    chk("abort_addr", 32'(fp_addr), 0);
    chk("abort_tcnt", 32'(timeout_cnt), 0);
    issue(1, 0, 32'hc000_0044, 4'hf, 0, 1, $urandom, 0);
    issue(1, 1, 32'hc000_0030, 4'hf, 32'h0bad_cafe, 2, $urandom, 0);
    for (int i = 0; i < 150; i++) begin
      int k, r, t;
      logic [31:0] a;
      logic [3:0] be;
      k = $urandom_range(9);
      r = $urandom_range(2);
      t = $urandom_range(4);
      a = {t < 3 ? 8'hc0 : t == 3 ? 8'h80 : 8'hc1, 24'($urandom)};
      be = $urandom_range(3) == 0 ? 4'($urandom) : 4'hf;
      issue(r != 1, r != 0, a, be, $urandom,
            k < 6 ? k : k == 6 ? TO - 1 : k == 7 ? TO : NEVER, $urandom, 1);
    end
    for (int i = 0; i < 300; i++) issue(1, 0, 32'hc000_0000, 4'hf, 0, NEVER, $urandom, 0);
    @(negedge clk);
    chk("tcnt_saturated", 32'(timeout_cnt), 255);
    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
